// File: rtl/a2d_spi_slave_if.sv
// rtl/a2d_spi_slave_if.sv - SPI link signals between A2D master and converter model
interface a2d_spi_slave_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_spi_slave.sv
// rtl/a2d_spi_slave.sv - SPI mode-0 responder emulating an 8-channel 12-bit A2D converter
// Optional ADC_RAMP_EN: each valid command bumps the previously selected channel by RAMP_STEP.
module a2d_spi_slave #(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 12,
    parameter int FRAME_W     = 16,
    parameter int SYNC_STAGES = 2
`ifdef ADC_RAMP_EN
    ,
    parameter int RAMP_STEP   = 1
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    a2d_spi_slave_if.slave            spi,
    input  logic                      wr_en,
    input  logic [$clog2(NUM_CH)-1:0] wr_chnl,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      cmd_vld,
    output logic [$clog2(NUM_CH)-1:0] cmd_chnl,
    output logic                      frm_err
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam int PAD_W = FRAME_W - DATA_W;
    localparam int RX_W  = FRAME_W - 2;
    localparam int SW    = SYNC_STAGES + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e                 state_q, state_d;
    logic [SW-1:0]          ss_sync_q, ss_sync_d;
    logic [SW-1:0]          sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [FRAME_W-1:0]     tx_q, tx_d;
    logic [RX_W-1:0]        rx_q, rx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   miso_q, miso_d;
    logic                   cmd_vld_q, cmd_vld_d;
    logic                   frm_err_q, frm_err_d;
    logic [CH_W-1:0]        cmd_chnl_q, cmd_chnl_d;
    logic [DATA_W-1:0]      val_q [NUM_CH];
    logic [DATA_W-1:0]      val_d [NUM_CH];

    logic              ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;
    logic [DATA_W-1:0] ld_val;

    // The extra top flop of each sync chain holds the previous synchronized value for edge detection
    assign ss_fall   =  ss_sync_q[SYNC_STAGES]   & ~ss_sync_q[SYNC_STAGES-1];
    assign ss_rise   = ~ss_sync_q[SYNC_STAGES]   &  ss_sync_q[SYNC_STAGES-1];
    assign sclk_rise = ~sclk_sync_q[SYNC_STAGES] &  sclk_sync_q[SYNC_STAGES-1];
    assign sclk_fall =  sclk_sync_q[SYNC_STAGES] & ~sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    =  mosi_sync_q[SYNC_STAGES-1];

    // A host write landing on the selected channel in the load cycle is forwarded straight out
    assign ld_val = (wr_en && wr_chnl == cmd_chnl_q) ? wr_data : val_q[cmd_chnl_q];

    always_comb begin
        ss_sync_d   = SW'({ss_sync_q, spi.SS_n});
        sclk_sync_d = SW'({sclk_sync_q, spi.SCLK});
        mosi_sync_d = SYNC_STAGES'({mosi_sync_q, spi.MOSI});
        state_d     = state_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        cnt_d       = cnt_q;
        miso_d      = miso_q;
        cmd_vld_d   = 1'b0;
        frm_err_d   = 1'b0;
        cmd_chnl_d  = cmd_chnl_q;
        val_d       = val_q;

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    tx_d    = {{PAD_W{1'b0}}, ld_val};
                    miso_d  = tx_d[FRAME_W-1];
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d = DONE;
                end else if (sclk_rise) begin
                    rx_d = {rx_q[RX_W-2:0], mosi_s};
                    if (cnt_q != CNT_W'(FRAME_W))
                        cnt_d = cnt_q + 1'b1;
                end else if (sclk_fall) begin
                    tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
                    miso_d = tx_d[FRAME_W-1];
                end
            end
            DONE: begin
                if (cnt_q == CNT_W'(FRAME_W)) begin
                    cmd_chnl_d = rx_q[RX_W-1 -: CH_W];
                    cmd_vld_d  = 1'b1;
`ifdef ADC_RAMP_EN
                    val_d[cmd_chnl_q] = val_q[cmd_chnl_q] + DATA_W'(RAMP_STEP);
`endif
                end else begin
                    frm_err_d = 1'b1;
                end
                tx_d    = '0;
                miso_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Host write is applied last so it overrides any ramp increment on the same channel
        if (wr_en)
            val_d[wr_chnl] = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ss_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            cnt_q       <= '0;
            miso_q      <= 1'b0;
            cmd_vld_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            cmd_chnl_q  <= '0;
            val_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            ss_sync_q   <= ss_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cnt_q       <= cnt_d;
            miso_q      <= miso_d;
            cmd_vld_q   <= cmd_vld_d;
            frm_err_q   <= frm_err_d;
            cmd_chnl_q  <= cmd_chnl_d;
            val_q       <= val_d;
        end
    end

    assign spi.MISO = miso_q;
    assign cmd_vld  = cmd_vld_q;
    assign frm_err  = frm_err_q;
    assign cmd_chnl = cmd_chnl_q;
endmodule

// File: tb/tb_a2d_spi_slave.sv
// tb/tb_a2d_spi_slave.sv - scoreboard bench for a2d_spi_slave
module tb_a2d_spi_slave;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_chnl;
    logic [11:0] wr_data;
    logic        cmd_vld;
    logic [2:0]  cmd_chnl;
    logic        frm_err;

    a2d_spi_slave_if spi_if ();

    a2d_spi_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi      (spi_if),
        .wr_en    (wr_en),
        .wr_chnl  (wr_chnl),
        .wr_data  (wr_data),
        .cmd_vld  (cmd_vld),
        .cmd_chnl (cmd_chnl),
        .frm_err  (frm_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          vld_cnt  = 0;
    int          err_cnt  = 0;
    logic [11:0] model_val [8];
    logic [2:0]  model_chnl;
    logic [15:0] exp_q [$];

    always @(negedge clk) begin
        if (cmd_vld === 1'b1) vld_cnt++;
        if (frm_err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model_val[i] = 12'h000;
        model_chnl = 3'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        spi_if.SS_n = 1'b1;
        spi_if.SCLK = 1'b0;
        spi_if.MOSI = 1'b0;
        wr_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic hwrite(input logic [2:0] ch, input logic [11:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        wr_chnl = ch;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        model_val[ch] = d;
    endtask

    // Mode-0 master: MISO sampled at each rise, MOSI changed on each fall; half period = 5 clk
    task automatic spi_xfer(input logic [15:0] mo, input int nbits, input bit end_frame,
                            input bit byp, input logic [11:0] byp_data, output logic [15:0] mi);
        mi = 16'h0000;
        @(negedge clk);
        spi_if.SS_n = 1'b0;
        spi_if.MOSI = mo[15];
        if (byp) begin
            repeat (2) @(negedge clk);
            wr_en = 1'b1;
            wr_chnl = model_chnl;
            wr_data = byp_data;
            @(negedge clk);
            wr_en = 1'b0;
            repeat (2) @(negedge clk);
        end else begin
            repeat (5) @(negedge clk);
        end
        for (int i = 0; i < nbits; i++) begin
            mi[15-i] = spi_if.MISO;
            spi_if.SCLK = 1'b1;
            repeat (5) @(negedge clk);
            spi_if.SCLK = 1'b0;
            if (i < 15) spi_if.MOSI = mo[14-i];
            repeat (5) @(negedge clk);
        end
        if (end_frame) begin
            spi_if.SS_n = 1'b1;
            spi_if.MOSI = 1'b0;
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic frame(input string tag, input logic [15:0] mo, input bit byp, input logic [11:0] bd);
        logic [15:0] mi;
        int v0, e0;
        if (byp) model_val[model_chnl] = bd;
        exp_q.push_back({4'h0, model_val[model_chnl]});
        v0 = vld_cnt;
        e0 = err_cnt;
        spi_xfer(mo, 16, 1'b1, byp, bd, mi);
        check({tag, "_miso"}, mi, exp_q.pop_front());
`ifdef ADC_RAMP_EN
        model_val[model_chnl] = model_val[model_chnl] + 12'd1;
`endif
        model_chnl = mo[13:11];
        check({tag, "_vld"}, vld_cnt - v0, 1);
        check({tag, "_err"}, err_cnt - e0, 0);
        check({tag, "_chnl"}, cmd_chnl, model_chnl);
    endtask

    initial begin
        logic [15:0] mi;
        logic [15:0] ex;
        int v0, e0;
        rst_n = 1'b0;
        wr_en = 1'b0;
        wr_chnl = 3'd0;
        wr_data = 12'h000;
        spi_if.SS_n = 1'b1;
        spi_if.SCLK = 1'b0;
        spi_if.MOSI = 1'b0;
        do_reset();

        check("rst_miso", spi_if.MISO, 0);
        check("rst_vld", cmd_vld, 0);
        check("rst_chnl", cmd_chnl, 0);
        check("rst_err", frm_err, 0);

        hwrite(3'd3, 12'hA5C);
        frame("f1", 16'h1800, 1'b0, 12'h0);
        frame("f2", 16'h1800, 1'b0, 12'h0);

        for (int i = 0; i < 8; i++) hwrite(3'(i), 12'(12'h100 * i + i));
        frame("c7", 16'h3800, 1'b0, 12'h0);
        frame("c0", 16'h0000, 1'b0, 12'h0);
        frame("c5", 16'h2800, 1'b0, 12'h0);

        // Short frame: 9 clocks then SS_n high
        exp_q.push_back({4'h0, model_val[model_chnl]});
        v0 = vld_cnt;
        e0 = err_cnt;
        spi_xfer(16'h1000, 9, 1'b1, 1'b0, 12'h0, mi);
        ex = exp_q.pop_front();
        check("short_miso", mi & 16'hFF80, ex & 16'hFF80);
        check("short_err", err_cnt - e0, 1);
        check("short_vld", vld_cnt - v0, 0);
        check("short_chnl", cmd_chnl, model_chnl);
        frame("after_short", 16'h1000, 1'b0, 12'h0);

        frame("bypass", 16'h1000, 1'b1, 12'h3FF);

        // Reset in the middle of a frame
        hwrite(3'd0, 12'h777);
        exp_q.push_back({4'h0, model_val[model_chnl]});
        v0 = vld_cnt;
        e0 = err_cnt;
        spi_xfer(16'h1000, 8, 1'b0, 1'b0, 12'h0, mi);
        ex = exp_q.pop_front();
        check("mid_miso", mi & 16'hFF00, ex & 16'hFF00);
        check("mid_miso_bit", spi_if.MISO, ex[7]);
        rst_n = 1'b0;
        #1;
        check("mid_rst_miso", spi_if.MISO, 0);
        check("mid_rst_chnl", cmd_chnl, 0);
        spi_if.SS_n = 1'b1;
        spi_if.SCLK = 1'b0;
        spi_if.MOSI = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        check("mid_rst_vld", vld_cnt - v0, 0);
        check("mid_rst_err", err_cnt - e0, 0);
        frame("post_rst", 16'h0000, 1'b0, 12'h0);

`ifdef ADC_RAMP_EN
        hwrite(3'd1, 12'hFFF);
        frame("ramp_sel", 16'h0800, 1'b0, 12'h0);
        frame("ramp_a", 16'h0800, 1'b0, 12'h0);
        frame("ramp_b", 16'h0800, 1'b0, 12'h0);
        frame("ramp_c", 16'h0800, 1'b0, 12'h0);
`endif

        check("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
